id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register and operand-forwarding stage for the 5-stage MIPS core. It sits directly upstream of the ALU. Each cycle it captures the decoded instruction from ID, then resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU `A`, `B` and `ALUOp` inputs, and detects load-use hazards so a bubble is inserted.

## Interface

Parameters: none. Widths are fixed by the ISA: 32-bit data, 5-bit register numbers, 5-bit ALUOp.

- `clk` in 1 — core clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `id_valid` in 1 — ID holds a real instruction.
- `id_alu_op` in 5 — ALUOp code, same encoding as the ALU (0 = zero, 1–18 = operations).
- `id_rs`, `id_rt` in 5 — source register numbers.
- `id_rs_data`, `id_rt_data` in 32 — register-file read data.
- `id_imm` in 16 — instruction immediate.
- `id_imm_sext` in 1 — 1 = sign-extend `id_imm`, 0 = zero-extend.
- `id_shamt` in 5 — shift amount field.
- `id_a_sel` in 1 — 0 = A from rs, 1 = A = {27'b0, shamt}.
- `id_b_sel` in 1 — 0 = B from rt, 1 = B = extended immediate.
- `id_rd` in 5 — destination register number.
- `id_reg_write` in 1 — instruction writes the register file.
- `id_mem_read` in 1 — instruction is a load.
- `stall` in 1 — downstream hold; freeze this register.
- `flush` in 1 — squash the contents of this stage (branch or exception).
- `mem_reg_write` in 1, `mem_rd` in 5, `mem_result` in 32 — EX/MEM forwarding source.
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_result` in 32 — MEM/WB forwarding source.
- `ex_valid` out 1 — EX holds a real instruction.
- `ex_alu_op` out 5 — to ALU `ALUOp`.
- `ex_a`, `ex_b` out 32 — to ALU `A`, `B`.
- `ex_store_data` out 32 — forwarded rt value, for stores.
- `ex_rd` out 5, `ex_reg_write` out 1, `ex_mem_read` out 1 — passed on to EX/MEM.
- `load_use_hazard` out 1 — combinational; ID/IF must hold when this is high.

## Operation

**Registered fields:** valid, alu_op, rs, rt, rs_data, rt_data, ext_imm (32 bits, extended at capture), shamt, a_sel, b_sel, rd, reg_write, mem_read.

**Next-state priority, per rising edge:**
- `flush`: load a bubble (valid=0, alu_op=0, reg_write=0, mem_read=0, rd=0). Data fields are don't-care.
- else `stall`: hold all fields unchanged.
- else `load_use_hazard`: load a bubble.
- else: capture the ID inputs. If `id_valid`=0, force reg_write=0 and mem_read=0.

**Load-use hazard:** `load_use_hazard` = `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & `id_valid` & ((`ex_rd`==`id_rs`) | (`ex_rd`==`id_rt`)).

**Forwarding** (combinational, applied independently to the registered rs and rt):
- If `mem_reg_write` & `mem_rd`≠0 & `mem_rd`==reg, use `mem_result`.
- else if `wb_reg_write` & `wb_rd`≠0 & `wb_rd`==reg, use `wb_result`.
- else use the registered data.
- Register 0 is never forwarded; its value is always the registered data.
- MEM has priority over WB when both match.

**Operand select:**
- `ex_a` = a_sel ? {27'b0, shamt} : fwd_rs.
- `ex_b` = b_sel ? ext_imm : fwd_rt.
- `ex_store_data` = fwd_rt, regardless of b_sel.

**Pass-through:** `ex_alu_op`, `ex_rd`, `ex_reg_write`, `ex_mem_read` and `ex_valid` are the registered values. A bubble presents alu_op=0, so the ALU outputs 0.

## Timing

- **Reset:** on asynchronous assertion of `rst_n`=0, every register clears to 0 immediately. Outputs then read `ex_valid`=0 and `ex_alu_op`=0, and `ex_rd`, `ex_reg_write`, `ex_mem_read` and `load_use_hazard` are all 0. `ex_a`, `ex_b` and `ex_store_data` are 0 unless a forwarding input matches, which cannot happen because rs=rt=0. Deassertion is not special-cased.
- **Latency:** ID inputs appear on the EX outputs one cycle after a capturing edge.
- **Forwarding path:** purely combinational within the cycle. A change on `mem_*` or `wb_*` is reflected on `ex_a`, `ex_b` and `ex_store_data` in the same cycle.
- **Stall:** holding over N cycles keeps the registered fields constant. Forwarded values may still change as the MEM/WB contents change.
- **Simultaneous events:**
  - `flush` & `stall` gives a bubble.
  - `stall` & hazard gives a hold. `load_use_hazard` still reflects the live comparison.
- **Reset mid-stall or mid-hazard:** the stage becomes a bubble immediately.

## Test plan

- **Reset:** `rst_n`=0 mid-stream → all outputs 0 asynchronously, before the next edge. First capture after release → `ex_alu_op` equals the ID value.
- **Plain capture and immediates:**
  - ID addu, rs=r1 (0x5), rt=r2 (0x7), no forwarding → next cycle `ex_a`=5, `ex_b`=7, `ex_alu_op`=2.
  - imm=0x8000, sext=1, b_sel=1 → `ex_b`=0xFFFF8000.
  - sext=0 → `ex_b`=0x00008000.
- **Forwarding priority:**
  - Registered rs=r3 with MEM (rd=3, 0xAA) and WB (rd=3, 0xBB) both matching → `ex_a`=0xAA.
  - With MEM reg_write=0 → `ex_a`=0xBB.
  - rs=r0 with MEM rd=0, reg_write=1 → `ex_a` = registered data.
- **Shift operands:** sll, shamt=4, a_sel=1, rt forwarded 0x1 from WB → `ex_a`=4, `ex_b`=1, `ex_store_data`=1.
- **Load-use hazard:** EX lw rd=r5, ID uses rs=r5 → `load_use_hazard`=1. Next cycle → `ex_valid`=0, `ex_alu_op`=0, `ex_reg_write`=0. The following cycle → the held instruction is captured.
- **Stall/flush precedence:**
  - `stall`=1 for 3 cycles → fields held.
  - `stall`=1 & `flush`=1 → bubble next cycle.
  - `id_valid`=0 capture → `ex_reg_write`=0 even if `id_reg_write`=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// ID inputs reach EX one cycle after a capturing edge; stall holds the register, flush/hazard load a bubble.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_alu_op,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [15:0] id_imm,
   input  logic        id_imm_sext,
   input  logic [4:0]  id_shamt,
   input  logic        id_a_sel,
   input  logic        id_b_sel,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_result,
   output logic        ex_valid,
   output logic [4:0]  ex_alu_op,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        load_use_hazard
);

   typedef struct packed {
      logic        valid;
      logic [4:0]  alu_op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] rs_dat;
      logic [31:0] rt_dat;
      logic [31:0] ext_imm;
      logic [4:0]  shamt;
      logic        a_sel;
      logic        b_sel;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
   } ex_fields_t;

   ex_fields_t  stage_d;
   ex_fields_t  stage_q;
   logic [31:0] id_ext_imm;
   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;

   // MEM is the younger producer, so it wins over WB; r0 is never forwarded.
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  src,
      input logic [31:0] reg_dat,
      input logic        m_we,
      input logic [4:0]  m_rd,
      input logic [31:0] m_dat,
      input logic        w_we,
      input logic [4:0]  w_rd,
      input logic [31:0] w_dat
   );
      logic [31:0] r;
      r = reg_dat;
      if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
         r = m_dat;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
         r = w_dat;
      end
      return r;
   endfunction

   assign id_ext_imm = id_imm_sext ? {{16{id_imm[15]}}, id_imm} : {16'b0, id_imm};

   assign load_use_hazard = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & id_valid &
                            ((stage_q.rd == id_rs) | (stage_q.rd == id_rt));

   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d = '0;
      end else if (stall) begin
         stage_d = stage_q;
      end else if (load_use_hazard) begin
         stage_d = '0;
      end else begin
         stage_d.valid     = id_valid;
         stage_d.alu_op    = id_alu_op;
         stage_d.rs        = id_rs;
         stage_d.rt        = id_rt;
         stage_d.rs_dat    = id_rs_data;
         stage_d.rt_dat    = id_rt_data;
         stage_d.ext_imm   = id_ext_imm;
         stage_d.shamt     = id_shamt;
         stage_d.a_sel     = id_a_sel;
         stage_d.b_sel     = id_b_sel;
         stage_d.rd        = id_rd;
         stage_d.reg_write = id_reg_write & id_valid;
         stage_d.mem_read  = id_mem_read & id_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      fwd_rs = fwd_sel(stage_q.rs, stage_q.rs_dat, mem_reg_write, mem_rd, mem_result,
                       wb_reg_write, wb_rd, wb_result);
      fwd_rt = fwd_sel(stage_q.rt, stage_q.rt_dat, mem_reg_write, mem_rd, mem_result,
                       wb_reg_write, wb_rd, wb_result);
   end

   assign ex_a          = stage_q.a_sel ? {27'b0, stage_q.shamt} : fwd_rs;
   assign ex_b          = stage_q.b_sel ? stage_q.ext_imm : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_valid      = stage_q.valid;
   assign ex_alu_op     = stage_q.alu_op;
   assign ex_rd         = stage_q.rd;
   assign ex_reg_write  = stage_q.reg_write;
   assign ex_mem_read   = stage_q.mem_read;

endmodule
